// File: rtl/core_ex_trap_ctrl.sv
// core_ex_trap_ctrl: commit-stage trap controller. Resolves interrupts, ECALL/EBREAK,
//   MRET and branch mispredicts for one committing instruction per cycle.
// Latency: handshake at edge N -> CSR strobes + flush in cycle N+1 -> ready again in N+2.
// Backpressure: cmt_ready drops for the single cycle spent in TRAP/MRET/BFLUSH.
// Ports: cmt_* commit handshake and instruction context from EX; irq_i interrupt lines;
//   csr_*_r current CSR values; cmt_*_en / cmt_* CSR write-back; irq_pending captured
//   lines; flush_req / flush_pc registered one-cycle redirect.
module core_ex_trap_ctrl #(
  parameter int                 XLEN        = 32,
  parameter int                 PC_WIDTH    = 32,
  parameter int                 IRQ_NUM     = 3,
  parameter logic [IRQ_NUM-1:0] IRQ_EDGE    = '0,
  parameter bit                 VECTORED_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmt_valid,
  output logic                cmt_ready,
  input  logic [PC_WIDTH-1:0] cmt_pc,
  input  logic [PC_WIDTH-1:0] cmt_bj_pc,
  input  logic                cmt_branch_predict,
  input  logic                cmt_branch_jump,
  input  logic                cmt_ecall,
  input  logic                cmt_ebreak,
  input  logic                cmt_mret,
  input  logic [IRQ_NUM-1:0]  irq_i,
  input  logic [XLEN-1:0]     csr_mstatus_r,
  input  logic [XLEN-1:0]     csr_mie_r,
  input  logic [XLEN-1:0]     csr_mtvec_r,
  input  logic [XLEN-1:0]     csr_mepc_r,
  output logic                cmt_mstatus_en,
  output logic                cmt_mcause_en,
  output logic                cmt_mepc_en,
  output logic [XLEN-1:0]     cmt_mstatus,
  output logic [XLEN-1:0]     cmt_mcause,
  output logic [XLEN-1:0]     cmt_mepc,
  output logic [IRQ_NUM-1:0]  irq_pending,
  output logic                flush_req,
  output logic [PC_WIDTH-1:0] flush_pc
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAP   = 2'd1,
    ST_MRET   = 2'd2,
    ST_BFLUSH = 2'd3
  } state_t;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // Machine-level cause code for local interrupt line i.
  function automatic logic [4:0] irq_code(input int i);
    case (i)
      0:       irq_code = 5'd3;
      1:       irq_code = 5'd7;
      2:       irq_code = 5'd11;
      default: irq_code = 5'(16 + i - 3);
    endcase
  endfunction

  state_t               state;
  logic [IRQ_NUM-1:0]   irq_prev;
  logic [IRQ_NUM-1:0]   pend;
  logic [IRQ_NUM-1:0]   pend_nxt;
  logic [IRQ_NUM-1:0]   take_mask;
  logic                 irq_take;
  logic [4:0]           irq_code_sel;
  logic                 hs;
  logic                 is_exc;
  logic                 is_misp;
  logic [XLEN-1:0]      trap_cause;
  logic [XLEN-1:0]      tvec_base;
  logic [XLEN-1:0]      tvec_addr;
  logic [XLEN-1:0]      mstatus_trap;
  logic [XLEN-1:0]      mstatus_mret;
  logic [XLEN-1:0]      mepc_aligned;
  logic [PC_WIDTH-1:0]  bflush_pc;

  // Only the mie bits mapped to implemented lines are consulted.
  logic unused_mie;
  assign unused_mie = ^csr_mie_r;

  assign hs          = cmt_valid & cmt_ready & (state == ST_IDLE);
  assign is_exc      = cmt_ecall | cmt_ebreak;
  assign is_misp     = cmt_branch_predict ^ cmt_branch_jump;
  assign irq_pending = pend;

  // Highest eligible index wins: later iterations overwrite earlier ones.
  always_comb begin
    irq_take     = 1'b0;
    irq_code_sel = '0;
    take_mask    = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (pend[i] && csr_mie_r[irq_code(i)] && csr_mstatus_r[MIE_BIT]) begin
        irq_take     = 1'b1;
        irq_code_sel = irq_code(i);
        take_mask    = IRQ_NUM'(1) << i;
      end
    end
  end

  // A new rising edge on the line being taken wins over the clear, so it is not lost.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (IRQ_EDGE[i]) begin
        pend_nxt[i] = (pend[i] & ~(hs & take_mask[i])) | (irq_i[i] & ~irq_prev[i]);
      end else begin
        pend_nxt[i] = irq_i[i];
      end
    end
  end

  always_comb begin
    trap_cause = '0;
    if (irq_take) begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[4:0]    = irq_code_sel;
    end else begin
      trap_cause[4:0] = cmt_ecall ? 5'd11 : 5'd3;
    end
  end

  assign tvec_base = csr_mtvec_r & ~XLEN'(3);
  assign tvec_addr = (VECTORED_EN && (csr_mtvec_r[1:0] == 2'b01) && irq_take)
                     ? tvec_base + XLEN'({irq_code_sel, 2'b00})
                     : tvec_base;

  always_comb begin
    mstatus_trap           = csr_mstatus_r;
    mstatus_trap[MPIE_BIT] = csr_mstatus_r[MIE_BIT];
    mstatus_trap[MIE_BIT]  = 1'b0;
    mstatus_trap[12:11]    = 2'b11;
  end

  always_comb begin
    mstatus_mret           = csr_mstatus_r;
    mstatus_mret[MIE_BIT]  = csr_mstatus_r[MPIE_BIT];
    mstatus_mret[MPIE_BIT] = 1'b1;
    mstatus_mret[12:11]    = 2'b11;
  end

  assign mepc_aligned = csr_mepc_r & ~XLEN'(3);
  assign bflush_pc    = cmt_branch_jump ? cmt_bj_pc : cmt_pc + PC_WIDTH'(4);

  // All event context is captured into the output registers at the handshake,
  // so each non-IDLE state only has to hold them for its single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cmt_ready      <= 1'b1;
      cmt_mstatus_en <= 1'b0;
      cmt_mcause_en  <= 1'b0;
      cmt_mepc_en    <= 1'b0;
      cmt_mstatus    <= '0;
      cmt_mcause     <= '0;
      cmt_mepc       <= '0;
      flush_req      <= 1'b0;
      flush_pc       <= '0;
      pend           <= '0;
      irq_prev       <= '0;
    end else begin
      irq_prev       <= irq_i;
      pend           <= pend_nxt;
      state          <= ST_IDLE;
      cmt_ready      <= 1'b1;
      cmt_mstatus_en <= 1'b0;
      cmt_mcause_en  <= 1'b0;
      cmt_mepc_en    <= 1'b0;
      cmt_mstatus    <= '0;
      cmt_mcause     <= '0;
      cmt_mepc       <= '0;
      flush_req      <= 1'b0;
      flush_pc       <= '0;
      if (hs) begin
        if (irq_take || is_exc) begin
          state          <= ST_TRAP;
          cmt_ready      <= 1'b0;
          cmt_mstatus_en <= 1'b1;
          cmt_mcause_en  <= 1'b1;
          cmt_mepc_en    <= 1'b1;
          cmt_mstatus    <= mstatus_trap;
          cmt_mcause     <= trap_cause;
          cmt_mepc       <= XLEN'(cmt_pc);
          flush_req      <= 1'b1;
          flush_pc       <= tvec_addr[PC_WIDTH-1:0];
        end else if (cmt_mret) begin
          state          <= ST_MRET;
          cmt_ready      <= 1'b0;
          cmt_mstatus_en <= 1'b1;
          cmt_mstatus    <= mstatus_mret;
          flush_req      <= 1'b1;
          flush_pc       <= mepc_aligned[PC_WIDTH-1:0];
        end else if (is_misp) begin
          state     <= ST_BFLUSH;
          cmt_ready <= 1'b0;
          flush_req <= 1'b1;
          flush_pc  <= bflush_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_ex_trap_ctrl.sv
module tb_core_ex_trap_ctrl;

  localparam int         XLEN = 32;
  localparam int         PCW  = 32;
  localparam int         NIRQ = 3;
  localparam logic [2:0] EDGE = 3'b110;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            cmt_ready;
  logic [PCW-1:0]  pc, bj;
  logic            pred, jump, ecall, ebreak, mret;
  logic [NIRQ-1:0] irq;
  logic [XLEN-1:0] mst, mie, mtvec, mepc;
  logic            mst_en, cause_en, mepc_en;
  logic [XLEN-1:0] o_mst, o_cause, o_mepc;
  logic [NIRQ-1:0] irq_pending;
  logic            flush_req;
  logic [PCW-1:0]  flush_pc;

  core_ex_trap_ctrl #(
    .XLEN(XLEN), .PC_WIDTH(PCW), .IRQ_NUM(NIRQ), .IRQ_EDGE(EDGE), .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cmt_valid(valid), .cmt_ready(cmt_ready),
    .cmt_pc(pc), .cmt_bj_pc(bj), .cmt_branch_predict(pred), .cmt_branch_jump(jump),
    .cmt_ecall(ecall), .cmt_ebreak(ebreak), .cmt_mret(mret), .irq_i(irq),
    .csr_mstatus_r(mst), .csr_mie_r(mie), .csr_mtvec_r(mtvec), .csr_mepc_r(mepc),
    .cmt_mstatus_en(mst_en), .cmt_mcause_en(cause_en), .cmt_mepc_en(mepc_en),
    .cmt_mstatus(o_mst), .cmt_mcause(o_cause), .cmt_mepc(o_mepc),
    .irq_pending(irq_pending), .flush_req(flush_req), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmt();
    valid = 1'b0; pred = 1'b0; jump = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    pc = '0; bj = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_cmt(); irq = '0;
    mst = '0; mie = '0; mtvec = '0; mepc = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic int code_of(input int i);
    if (i == 0) return 3;
    if (i == 1) return 7;
    if (i == 2) return 11;
    return 16 + i - 3;
  endfunction

  // ---------------- table of single-instruction events ----------------
  typedef struct {
    logic [31:0] pc, bj;
    logic        pred, jump, ecall, ebreak, mret;
    logic [31:0] mst, mtvec, mepc;
    logic [2:0]  exp_en;      // {mstatus, mcause, mepc}
    logic        exp_flush;
    logic [31:0] exp_fpc, exp_mst, exp_cause, exp_mepc;
  } vec_t;

  vec_t vt[10];

  // ---------------- behavioural reference for the random phase ----------------
  bit          m_busy;
  bit [2:0]    m_pend, m_prev;
  bit          e_ready, e_flush;
  bit [2:0]    e_en;
  bit [31:0]   e_fpc, e_mst, e_cause, e_mepc;

  task automatic model_eval();
    bit [2:0]  np;
    int        best;
    bit        intr;
    bit [31:0] base;
    e_ready = 1'b1; e_flush = 1'b0; e_en = 3'b000;
    e_fpc = 0; e_mst = 0; e_cause = 0; e_mepc = 0;
    if (rst) begin
      m_busy = 1'b0; m_pend = '0; m_prev = '0;
      return;
    end
    for (int i = 0; i < NIRQ; i++)
      np[i] = EDGE[i] ? (m_pend[i] | (irq[i] & ~m_prev[i])) : irq[i];
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (valid) begin
      best = -1;
      for (int i = 0; i < NIRQ; i++)
        if (m_pend[i] && mie[code_of(i)] && mst[3]) best = i;
      intr = (best >= 0);
      if (intr || ecall || ebreak) begin
        e_en = 3'b111; e_flush = 1'b1; e_mepc = pc; e_ready = 1'b0; m_busy = 1'b1;
        e_cause = intr ? (32'h8000_0000 | 32'(code_of(best))) : (ecall ? 32'd11 : 32'd3);
        e_mst = (mst & ~32'h1888) | 32'h1800 | (mst[3] ? 32'h80 : 32'h0);
        base = mtvec & ~32'h3;
        e_fpc = (intr && mtvec[1:0] == 2'b01) ? base + 32'(4 * code_of(best)) : base;
        if (intr && EDGE[best]) np[best] = irq[best] & ~m_prev[best];
      end else if (mret) begin
        e_en = 3'b100; e_flush = 1'b1; e_ready = 1'b0; m_busy = 1'b1;
        e_mst = (mst & ~32'h1888) | 32'h1880 | (mst[7] ? 32'h8 : 32'h0);
        e_fpc = mepc & ~32'h3;
      end else if (pred != jump) begin
        e_flush = 1'b1; e_ready = 1'b0; m_busy = 1'b1;
        e_fpc = jump ? bj : pc + 32'd4;
      end
    end
    m_pend = np;
    m_prev = irq;
  endtask

  initial begin
    vt[0] = '{32'h50,  32'h8000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
              3'b000, 1'b1, 32'h8000_0040, 32'h0, 32'h0, 32'h0};
    vt[1] = '{32'h100, 32'h9999_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
              3'b000, 1'b1, 32'h104, 32'h0, 32'h0, 32'h0};
    vt[2] = '{32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
              3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[3] = '{32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h1000, 32'h0,
              3'b111, 1'b1, 32'h1000, 32'h1880, 32'hB, 32'h200};
    vt[4] = '{32'h204, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1001, 32'h0,
              3'b111, 1'b1, 32'h1000, 32'h1800, 32'h3, 32'h204};
    vt[5] = '{32'h208, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h2000, 32'h0,
              3'b111, 1'b1, 32'h2000, 32'hFFFF_FFF7, 32'hB, 32'h208};
    vt[6] = '{32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1880, 32'h0, 32'h203,
              3'b100, 1'b1, 32'h200, 32'h1888, 32'h0, 32'h0};
    vt[7] = '{32'h304, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0001,
              3'b100, 1'b1, 32'h8000_0000, 32'h1880, 32'h0, 32'h0};
    vt[8] = '{32'h400, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
              3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[9] = '{32'h404, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10,
              3'b100, 1'b1, 32'h10, 32'h1880, 32'h0, 32'h0};

    do_reset();
    chk("reset_ready", cmt_ready, 1);
    chk("reset_flush", flush_req, 0);
    chk("reset_strobes", {mst_en, cause_en, mepc_en}, 0);
    chk("reset_pending", irq_pending, 0);

    // ---- table-driven single events ----
    for (int k = 0; k < 10; k++) begin
      pc = vt[k].pc; bj = vt[k].bj; pred = vt[k].pred; jump = vt[k].jump;
      ecall = vt[k].ecall; ebreak = vt[k].ebreak; mret = vt[k].mret;
      mst = vt[k].mst; mtvec = vt[k].mtvec; mepc = vt[k].mepc; mie = '0;
      valid = 1'b1;
      tick();
      clear_cmt();
      chk($sformatf("vec%0d_ready", k), cmt_ready, !(vt[k].exp_flush || vt[k].exp_en != 0));
      chk($sformatf("vec%0d_flush", k), flush_req, vt[k].exp_flush);
      chk($sformatf("vec%0d_strobes", k), {mst_en, cause_en, mepc_en}, vt[k].exp_en);
      if (vt[k].exp_flush) chk($sformatf("vec%0d_flush_pc", k), flush_pc, vt[k].exp_fpc);
      if (vt[k].exp_en[2]) chk($sformatf("vec%0d_mstatus", k), o_mst, vt[k].exp_mst);
      if (vt[k].exp_en[1]) chk($sformatf("vec%0d_mcause", k), o_cause, vt[k].exp_cause);
      if (vt[k].exp_en[0]) chk($sformatf("vec%0d_mepc", k), o_mepc, vt[k].exp_mepc);
      tick();
      chk($sformatf("vec%0d_ready_back", k), cmt_ready, 1);
      chk($sformatf("vec%0d_flush_once", k), flush_req, 0);
      chk($sformatf("vec%0d_strobes_once", k), {mst_en, cause_en, mepc_en}, 0);
    end

    // ---- vectored timer interrupt ----
    do_reset();
    mie = 32'h80; mst = 32'h8; mtvec = 32'h1001;
    irq = 3'b010; tick(); irq = 3'b000; tick();
    chk("vti_pending_set", irq_pending, 3'b010);
    valid = 1'b1; pc = 32'h300; tick(); clear_cmt();
    chk("vti_mcause", o_cause, 32'h8000_0007);
    chk("vti_flush_pc", flush_pc, 32'h101C);
    chk("vti_mepc", o_mepc, 32'h300);
    chk("vti_mstatus", o_mst, 32'h1880);
    chk("vti_pending_clr", irq_pending, 3'b000);
    tick();

    // ---- priority: MEI + MTI + ECALL, then with MIE=0 ----
    do_reset();
    mie = 32'h880; mst = 32'h8; mtvec = 32'h1000;
    irq = 3'b110; tick(); irq = 3'b000; tick();
    valid = 1'b1; ecall = 1'b1; pc = 32'h600; tick(); clear_cmt();
    chk("prio_mei_cause", o_cause, 32'h8000_000B);
    chk("prio_mti_still_pending", irq_pending, 3'b010);
    tick();
    mst = 32'h0;
    valid = 1'b1; ecall = 1'b1; pc = 32'h604; tick(); clear_cmt();
    chk("prio_exc_cause", o_cause, 32'hB);
    chk("prio_exc_flush_pc", flush_pc, 32'h1000);
    chk("prio_exc_pending_kept", irq_pending, 3'b010);
    tick();

    // ---- MRET, with an irq edge during the MRET cycle ----
    do_reset();
    mepc = 32'h203; mst = 32'h1880; mie = 32'h80; mtvec = 32'h1000;
    valid = 1'b1; mret = 1'b1; tick(); clear_cmt();
    chk("mret_mstatus", o_mst, 32'h1888);
    chk("mret_strobes", {mst_en, cause_en, mepc_en}, 3'b100);
    chk("mret_flush_pc", flush_pc, 32'h200);
    irq = 3'b010; tick(); irq = 3'b000;
    chk("mret_edge_captured", irq_pending, 3'b010);
    chk("mret_ready_back", cmt_ready, 1);
    mst = 32'h1888;
    valid = 1'b1; pc = 32'h400; tick(); clear_cmt();
    chk("mret_irq_taken_cause", o_cause, 32'h8000_0007);
    chk("mret_irq_taken_mepc", o_mepc, 32'h400);
    tick();

    // ---- reset coincident with TRAP ----
    do_reset();
    mtvec = 32'h1000;
    irq = 3'b010; tick(); irq = 3'b000; tick();
    valid = 1'b1; ecall = 1'b1; pc = 32'h500; tick(); clear_cmt();
    chk("rst_trap_entered", flush_req, 1);
    rst = 1'b1; tick();
    chk("rst_trap_strobes", {mst_en, cause_en, mepc_en}, 0);
    chk("rst_trap_flush", flush_req, 0);
    chk("rst_trap_ready", cmt_ready, 1);
    chk("rst_trap_pending", irq_pending, 0);
    rst = 1'b0; tick();
    chk("rst_trap_no_late_flush", flush_req, 0);
    chk("rst_trap_no_late_strobe", {mst_en, cause_en, mepc_en}, 0);

    // ---- randomized against the behavioural model ----
    irq = '0;
    for (int c = 0; c < 600; c++) begin
      rst    = (c == 0) || ($urandom_range(0, 63) == 0);
      valid  = 1'($urandom);
      pc     = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      bj     = $urandom;
      pred   = 1'($urandom);
      jump   = 1'($urandom);
      ecall  = ($urandom_range(0, 7) == 0);
      ebreak = ($urandom_range(0, 7) == 0);
      mret   = ($urandom_range(0, 7) == 0);
      irq    = irq ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
      mst    = $urandom;
      mie    = $urandom;
      mtvec  = $urandom;
      if (1'($urandom)) mtvec = (mtvec & ~32'h3) | 32'h1;
      mepc   = $urandom;
      model_eval();
      tick();
      chk("rnd_ready", cmt_ready, e_ready);
      chk("rnd_flush", flush_req, e_flush);
      chk("rnd_strobes", {mst_en, cause_en, mepc_en}, e_en);
      chk("rnd_pending", irq_pending, m_pend);
      if (e_flush) chk("rnd_flush_pc", flush_pc, e_fpc);
      if (e_en[2]) chk("rnd_mstatus", o_mst, e_mst);
      if (e_en[1]) chk("rnd_mcause", o_cause, e_cause);
      if (e_en[0]) chk("rnd_mepc", o_mepc, e_mepc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
